fetch_stage: RTL and testbench

Instruction-fetch stage of the MINI-MIPS core, directly upstream of the instruction memory. It owns the program counter and drives the word address into the combinational instruction memory. It registers the returned instruction into the IF/ID pipeline register with a valid flag for decode. It also handles stall, branch/jump redirect with wrong-path flush, and halt detection.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_stage_if.sv | 42 ++++
 rtl/fetch_perf_cnt.sv | 46 ++++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MINI-MIPS definitions: address width, opcode field, HALT opcode and
// fetch state encoding, plus small helpers used by the fetch stage.
package mips_pkg;

   localparam int unsigned ADDR_W     = 15;
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;

   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   // Word-address increment; wraps modulo 2^ADDR_W by truncation.
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

   function automatic logic is_halt(input logic [31:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB] == OP_HALT;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control from decode/execute, instruction-memory port and
// the IF/ID register outputs. master = fetch stage, slave = its environment.
interface fetch_stage_if;

   logic                       stall;
   logic                       redirect_valid;
   logic [mips_pkg::ADDR_W-1:0] redirect_target;
   logic [mips_pkg::ADDR_W-1:0] imem_addr;
   logic [31:0]                imem_instr;
   logic                       if_valid;
   logic [31:0]                if_instr;
   logic [mips_pkg::ADDR_W-1:0] if_pc;
   logic [mips_pkg::ADDR_W-1:0] if_pc_next;
   logic                       halted;

   modport master (
      input  stall,
      input  redirect_valid,
      input  redirect_target,
      input  imem_instr,
      output imem_addr,
      output if_valid,
      output if_instr,
      output if_pc,
      output if_pc_next,
      output halted
   );

   modport slave (
      output stall,
      output redirect_valid,
      output redirect_target,
      output imem_instr,
      input  imem_addr,
      input  if_valid,
      input  if_instr,
      input  if_pc,
      input  if_pc_next,
      input  halted
   );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Three saturating 32-bit event counters for the fetch stage: instructions
// loaded into IF/ID, stall cycles while running, and redirect (flush) cycles.
module fetch_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_evt,
   input  logic        stall_evt,
   input  logic        flush_evt,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls,
   output logic [31:0] perf_flushes
);

   logic [31:0] fetched_q, fetched_d;
   logic [31:0] stalls_q, stalls_d;
   logic [31:0] flushes_q, flushes_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic evt);
      return (evt && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
   endfunction

   // Next counts: increment on event, stick at all-ones.
   always_comb begin
      fetched_d = sat_inc(fetched_q, fetch_evt);
      stalls_d  = sat_inc(stalls_q, stall_evt);
      flushes_d = sat_inc(flushes_q, flush_evt);
   end

   // Counter registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetched_q <= '0;
         stalls_q  <= '0;
         flushes_q <= '0;
      end else begin
         fetched_q <= fetched_d;
         stalls_q  <= stalls_d;
         flushes_q <= flushes_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stalls  = stalls_q;
   assign perf_flushes = flushes_q;

endmodule

// File: rtl/fetch_stage.sv
// MINI-MIPS instruction fetch: PC register, next-PC mux, IF/ID register,
// stall/redirect handling and HALT detection. Optional performance counters
// are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic        clk,
   input  logic        rst,
   fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls,
   output logic [31:0] perf_flushes
`endif
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              if_valid_q, if_valid_d;
   logic [31:0]       if_instr_q, if_instr_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;
   logic [ADDR_W-1:0] if_pc_next_q, if_pc_next_d;

   // Next-state selection: redirect beats stall beats normal fetch.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      if_valid_d   = if_valid_q;
      if_instr_d   = if_instr_q;
      if_pc_d      = if_pc_q;
      if_pc_next_d = if_pc_next_q;
      if (bus.redirect_valid) begin
         // Flush the wrong-path instruction; also cancels a wrong-path HALT.
         pc_d       = bus.redirect_target;
         if_valid_d = 1'b0;
         state_d    = RUN;
      end else if (bus.stall) begin
         // Hold everything so decode sees stable outputs.
      end else if (state_q == RUN) begin
         if_valid_d   = 1'b1;
         if_instr_d   = bus.imem_instr;
         if_pc_d      = pc_q;
         if_pc_next_d = pc_inc(pc_q);
         if (is_halt(bus.imem_instr)) begin
            state_d = HALTED;
         end else begin
            pc_d = pc_inc(pc_q);
         end
      end else begin
         // HALTED: HALT has now been consumed once; PC stays frozen.
         if_valid_d = 1'b0;
      end
   end

   // PC, state and IF/ID registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         if_valid_q   <= 1'b0;
         if_instr_q   <= '0;
         if_pc_q      <= '0;
         if_pc_next_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         if_valid_q   <= if_valid_d;
         if_instr_q   <= if_instr_d;
         if_pc_q      <= if_pc_d;
         if_pc_next_q <= if_pc_next_d;
      end
   end

   assign bus.imem_addr  = pc_q;
   assign bus.if_valid   = if_valid_q;
   assign bus.if_instr   = if_instr_q;
   assign bus.if_pc      = if_pc_q;
   assign bus.if_pc_next = if_pc_next_q;
   assign bus.halted     = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
   logic fetch_evt;
   logic stall_evt;
   logic flush_evt;

   assign fetch_evt = !bus.redirect_valid && !bus.stall && (state_q == RUN);
   assign stall_evt = bus.stall && (state_q == RUN);
   assign flush_evt = bus.redirect_valid;

   fetch_perf_cnt u_perf_cnt (
      .clk          (clk),
      .rst          (rst),
      .fetch_evt    (fetch_evt),
      .stall_evt    (stall_evt),
      .flush_evt    (flush_evt),
      .perf_fetched (perf_fetched),
      .perf_stalls  (perf_stalls),
      .perf_flushes (perf_flushes)
   );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus pushes the expected outputs
// for each cycle, a negedge monitor pops and compares them.
module tb_fetch_stage;

   localparam logic [6:0] M_V   = 7'h01;
   localparam logic [6:0] M_I   = 7'h02;
   localparam logic [6:0] M_PC  = 7'h04;
   localparam logic [6:0] M_PCN = 7'h08;
   localparam logic [6:0] M_A   = 7'h10;
   localparam logic [6:0] M_H   = 7'h20;
   localparam logic [6:0] M_PF  = 7'h40;
   localparam logic [6:0] ALL6  = 7'h3F;

   typedef struct {
      string       name;
      logic [6:0]  m;
      logic        v;
      logic [31:0] ins;
      logic [14:0] pc;
      logic [14:0] pcn;
      logic [14:0] ad;
      logic        h;
      logic [31:0] pf;
      logic [31:0] ps;
      logic [31:0] pfl;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] mem [0:15];
   exp_t        q[$];
   exp_t        mon_e;
   int          n_pass;
   int          n_total;

   fetch_stage_if bus_if ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stalls;
   logic [31:0] perf_flushes;
`endif

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus_if)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stalls  (perf_stalls),
      .perf_flushes (perf_flushes)
`endif
   );

   // Combinational instruction memory: 16 words, above that the address itself.
   assign bus_if.imem_instr = (bus_if.imem_addr < 15'd16) ? mem[bus_if.imem_addr[3:0]]
                                                          : {17'h0, bus_if.imem_addr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t ex(input string n, input logic [6:0] m, input logic v,
                               input logic [31:0] ins, input logic [14:0] pc,
                               input logic [14:0] pcn, input logic [14:0] ad,
                               input logic h);
      exp_t e;
      e.name = n; e.m = m; e.v = v; e.ins = ins; e.pc = pc; e.pcn = pcn;
      e.ad = ad; e.h = h; e.pf = '0; e.ps = '0; e.pfl = '0;
      return e;
   endfunction

   function automatic exp_t wp(input exp_t ei, input logic [31:0] pf,
                               input logic [31:0] ps, input logic [31:0] pfl);
      exp_t e;
      e = ei;
      e.m = e.m | M_PF; e.pf = pf; e.ps = ps; e.pfl = pfl;
      return e;
   endfunction

   task automatic cmp(input string n, input string f, input logic [31:0] act,
                      input logic [31:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s.%s: got %h, expected %h", n, f, act, want);
   endtask

   task automatic cyc(input logic r, input logic st, input logic rv, input logic [14:0] tg,
                      input exp_t e);
      rst = r;
      bus_if.stall = st;
      bus_if.redirect_valid = rv;
      bus_if.redirect_target = tg;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         if (mon_e.m[0]) cmp(mon_e.name, "if_valid", {31'b0, bus_if.if_valid}, {31'b0, mon_e.v});
         if (mon_e.m[1]) cmp(mon_e.name, "if_instr", bus_if.if_instr, mon_e.ins);
         if (mon_e.m[2]) cmp(mon_e.name, "if_pc", {17'b0, bus_if.if_pc}, {17'b0, mon_e.pc});
         if (mon_e.m[3]) cmp(mon_e.name, "if_pc_next", {17'b0, bus_if.if_pc_next},
                             {17'b0, mon_e.pcn});
         if (mon_e.m[4]) cmp(mon_e.name, "imem_addr", {17'b0, bus_if.imem_addr},
                             {17'b0, mon_e.ad});
         if (mon_e.m[5]) cmp(mon_e.name, "halted", {31'b0, bus_if.halted}, {31'b0, mon_e.h});
`ifdef FETCH_PERF_CNT_EN
         if (mon_e.m[6]) begin
            cmp(mon_e.name, "perf_fetched", perf_fetched, mon_e.pf);
            cmp(mon_e.name, "perf_stalls", perf_stalls, mon_e.ps);
            cmp(mon_e.name, "perf_flushes", perf_flushes, mon_e.pfl);
         end
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass = 0;
      n_total = 0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 | i;
      mem[0] = 32'h0401_0001;
      mem[1] = 32'h4081_0012;
      rst = 1'b1;
      bus_if.stall = 1'b0;
      bus_if.redirect_valid = 1'b0;
      bus_if.redirect_target = '0;
      repeat (3) @(posedge clk);
      #1;

      // Reset then run
      cyc(0, 0, 0, 0, ex("reset", ALL6, 0, 32'h0, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, ex("run1", ALL6, 1, 32'h0401_0001, 0, 1, 1, 0));
      cyc(0, 0, 0, 0, ex("run2", ALL6, 1, 32'h4081_0012, 1, 2, 2, 0));
      cyc(0, 0, 0, 0, ex("run3", M_V | M_PC | M_A, 1, 0, 2, 0, 3, 0));
      cyc(0, 0, 0, 0, ex("run4", M_V | M_PC | M_A, 1, 0, 3, 0, 4, 0));

      // Stall three cycles with PC = 5
      for (int i = 0; i < 3; i++)
         cyc(0, 1, 0, 0, ex("stall", M_V | M_I | M_PC | M_PCN | M_A, 1, 32'h1000_0004,
                            4, 5, 5, 0));
      cyc(0, 0, 0, 0, ex("stall_rel", M_V | M_I | M_PC | M_PCN | M_A, 1, 32'h1000_0004,
                         4, 5, 5, 0));
      cyc(0, 0, 0, 0, ex("after_stall", M_V | M_I | M_PC | M_PCN | M_A, 1, 32'h1000_0005,
                         5, 6, 6, 0));
      cyc(0, 0, 0, 0, ex("seq6", M_V | M_PC | M_A, 1, 0, 6, 0, 7, 0));
      cyc(0, 0, 0, 0, ex("seq7", M_V | M_PC | M_A, 1, 0, 7, 0, 8, 0));

      // Redirect to 3 together with stall while fetching PC = 9
      cyc(0, 1, 1, 15'd3, ex("pre_redir", M_V | M_PC | M_A, 1, 0, 8, 0, 9, 0));
      mem[4] = 32'hFC00_0000;
      cyc(0, 0, 0, 0, ex("flush", M_V | M_A, 0, 0, 0, 0, 3, 0));
      cyc(0, 0, 0, 0, ex("redir_tgt", M_V | M_I | M_PC | M_PCN | M_A, 1, 32'h1000_0003,
                         3, 4, 4, 0));

      // HALT at word 4
      cyc(0, 0, 0, 0, ex("halt_cap", M_V | M_I | M_PC | M_PCN | M_A, 1, 32'hFC00_0000,
                         4, 5, 4, 0));
      for (int i = 0; i < 10; i++)
         cyc(0, 0, 0, 0, ex("halted", M_V | M_A | M_H, 0, 0, 0, 0, 4, 1));
      cyc(0, 0, 1, 15'd0, ex("halted_redir", M_V | M_A | M_H, 0, 0, 0, 0, 4, 1));
      mem[4] = 32'h1000_0004;
      cyc(0, 0, 0, 0, ex("resume", M_V | M_A | M_H, 0, 0, 0, 0, 0, 0));

      // Wrap at the top of the address space
      cyc(0, 0, 1, 15'h7FFF, ex("resume_pc", M_V | M_I | M_PC | M_A | M_H, 1, 32'h0401_0001,
                                0, 0, 1, 0));
      cyc(0, 0, 0, 0, ex("wrap_flush", M_V | M_A, 0, 0, 0, 0, 15'h7FFF, 0));
      cyc(0, 0, 0, 0, ex("wrap_pc", M_V | M_I | M_PC | M_PCN | M_A, 1, 32'h0000_7FFF,
                         15'h7FFF, 0, 0, 0));
      cyc(1, 0, 0, 0, wp(ex("wrap_next", M_V | M_PC | M_PCN | M_A, 1, 0, 0, 1, 1, 0),
                         32'd14, 32'd4, 32'd3));

      // Mid-run reset, then a counted segment: 10 fetches, 2 stalls, 1 redirect
      cyc(0, 0, 0, 0, wp(ex("reset2", ALL6, 0, 32'h0, 0, 0, 0, 0), 32'd0, 32'd0, 32'd0));
      for (int k = 0; k < 9; k++)
         cyc(0, 0, 0, 0, ex("perf_run", M_PC, 0, 0, 15'(k), 0, 0, 0));
      cyc(0, 1, 0, 0, ex("perf_stall", M_V | M_PC | M_A, 1, 0, 9, 0, 10, 0));
      cyc(0, 1, 0, 0, ex("perf_stall", M_V | M_PC | M_A, 1, 0, 9, 0, 10, 0));
      cyc(0, 0, 1, 15'd0, ex("perf_redir", M_V | M_PC | M_A, 1, 0, 9, 0, 10, 0));
      cyc(0, 0, 0, 0, wp(ex("perf_end", M_V | M_A, 0, 0, 0, 0, 0, 0), 32'd10, 32'd2, 32'd1));
      cyc(1, 0, 0, 0, ex("perf_rst", 7'h00, 0, 0, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, wp(ex("perf_clr", M_V | M_A, 0, 0, 0, 0, 0, 0), 32'd0, 32'd0, 32'd0));

      @(negedge clk);
      #1;
      n_total++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expectations, expected 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
